// File: rtl/alu_cmd_sequencer_if.sv
// Bundle for alu_cmd_sequencer: command stream, ALU operand/result wires,
// response stream and busy flag.
// slave  : the sequencer's view.
// master : the view of whatever surrounds it (host plus the attached ALU).
interface alu_cmd_sequencer_if #(
  parameter int N = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic         cmd_acc;

  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [N-1:0] alu_y;
  logic         alu_zero;
  logic         alu_cout;
  logic         alu_borrow;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_y;
  logic         rsp_zero;
  logic         rsp_cout;
  logic         rsp_borrow;

  logic         busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
    input  alu_y, alu_zero, alu_cout, alu_borrow,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_y, rsp_zero, rsp_cout, rsp_borrow,
    output busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
    output alu_y, alu_zero, alu_cout, alu_borrow,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_y, rsp_zero, rsp_cout, rsp_borrow,
    input  busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a small FIFO, issues one at a
// time to a bare combinational ALU through registered operands, and returns
// the captured result/flags on a valid/ready response stream.
// Optional feature macro: ALU_SEQ_ACC_EN (accumulator chaining via cmd_acc).
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | nothing in flight; waits for the FIFO to hold an entry
// S_ISSUE | operands driven to the ALU this cycle; result captured on exit
// S_RESP  | response held on rsp_*; waits for rsp_ready
module alu_cmd_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;

  logic [3:0]    r_fifo_op [DEPTH];
  logic [N-1:0]  r_fifo_a  [DEPTH];
  logic [N-1:0]  r_fifo_b  [DEPTH];
  logic [PW:0]   r_wr_ptr;
  logic [PW:0]   r_rd_ptr;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_rd_idx;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [N-1:0]  w_issue_a;

  logic [N-1:0]  r_alu_a;
  logic [N-1:0]  r_alu_b;
  logic [3:0]    r_alu_sel;

  logic          r_rsp_valid;
  logic [N-1:0]  r_rsp_y;
  logic          r_rsp_zero;
  logic          r_rsp_cout;
  logic          r_rsp_borrow;

  // FIFO pointers carry one wrap bit so full and empty are distinguishable
  // without a separate occupancy counter.
  assign w_wr_idx = r_wr_ptr[PW-1:0];
  assign w_rd_idx = r_rd_ptr[PW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (w_wr_idx == w_rd_idx);

  // cmd_ready reflects full only; a pop in the same cycle does not reopen it.
  assign w_push = bus.cmd_valid && !w_full;
  assign w_pop  = !w_empty &&
                  ((r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready));

`ifdef ALU_SEQ_ACC_EN
  logic          r_fifo_acc [DEPTH];
  logic [N-1:0]  r_acc;

  // Chained commands take operand A from the last captured result.
  assign w_issue_a = r_fifo_acc[w_rd_idx] ? r_acc : r_fifo_a[w_rd_idx];

  // Accumulator storage per FIFO entry; payload memory needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_acc[w_wr_idx] <= bus.cmd_acc;
    end
  end

  // Accumulator follows every captured ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (r_state == S_ISSUE) begin
      r_acc <= bus.alu_y;
    end
  end
`else
  logic w_unused_acc;

  // Without the accumulator, cmd_acc has no effect on the issued operands.
  assign w_unused_acc = bus.cmd_acc;
  assign w_issue_a    = r_fifo_a[w_rd_idx];
`endif

  // Command payload memory; contents are only read behind valid pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_op[w_wr_idx] <= bus.cmd_op;
      r_fifo_a[w_wr_idx]  <= bus.cmd_a;
      r_fifo_b[w_wr_idx]  <= bus.cmd_b;
    end
  end

  // FIFO pointer update; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Next-state decode for the issue/response sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = w_empty ? S_IDLE : S_ISSUE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ALU operand registers load on pop and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
    end else if (w_pop) begin
      r_alu_a   <= w_issue_a;
      r_alu_b   <= r_fifo_b[w_rd_idx];
      r_alu_sel <= r_fifo_op[w_rd_idx];
    end
  end

  // Response capture one cycle after issue; held until the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_y      <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_cout   <= 1'b0;
      r_rsp_borrow <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_y      <= bus.alu_y;
      r_rsp_zero   <= bus.alu_zero;
      r_rsp_cout   <= bus.alu_cout;
      r_rsp_borrow <= bus.alu_borrow;
    end else if ((r_state == S_RESP) && bus.rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign bus.cmd_ready  = !w_full;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_y      = r_rsp_y;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_cout   = r_rsp_cout;
  assign bus.rsp_borrow = r_rsp_borrow;
  assign bus.busy       = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU stand-in, an in-order
// expected-response queue checked every cycle, and directed vectors with
// literal expectations. Honours ALU_SEQ_ACC_EN when defined.
module tb_alu_cmd_sequencer;
  localparam int N = 8;
`ifdef ALU_SEQ_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] y;
    logic       zero;
    logic       cout;
    logic       borrow;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  res_t exp_q[$];
  logic [7:0] model_acc = '0;
  logic [7:0] m_a;
  res_t       m_r;
  res_t       alu_out;

  alu_cmd_sequencer_if #(.N(N)) bus();

  alu_cmd_sequencer #(.N(N), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    res_t r;
    logic [8:0] s;
    r = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r.y = s[7:0]; r.cout = s[8]; end
      4'd1: begin r.y = a - b; r.borrow = (a < b); end
      4'd2: r.y = a & b;
      4'd3: r.y = a | b;
      4'd4: r.y = a ^ b;
      default: r.y = 8'h00;
    endcase
    r.zero = (r.y == 8'h00);
    return r;
  endfunction

  // Combinational ALU attached to the sequencer.
  assign alu_out        = alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);
  assign bus.alu_y      = alu_out.y;
  assign bus.alu_zero   = alu_out.zero;
  assign bus.alu_cout   = alu_out.cout;
  assign bus.alu_borrow = alu_out.borrow;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the in-order response model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_acc = '0;
    end else begin
      check("busy", {31'd0, bus.busy}, {31'd0, exp_q.size() != 0});
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_spurious", {31'd0, bus.rsp_valid}, 32'd0);
        end else begin
          check("model_rsp_y", {24'd0, bus.rsp_y}, {24'd0, exp_q[0].y});
          check("model_rsp_flags", {29'd0, bus.rsp_zero, bus.rsp_cout, bus.rsp_borrow},
                {29'd0, exp_q[0].zero, exp_q[0].cout, exp_q[0].borrow});
          if (bus.rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        m_a = (ACC_EN && bus.cmd_acc) ? model_acc : bus.cmd_a;
        m_r = alu_ref(bus.cmd_op, m_a, bus.cmd_b);
        model_acc = m_r.y;
        exp_q.push_back(m_r);
      end
    end
  end

  // Drive a command from posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic acc);
    int k;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_acc   = acc;
    k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.cmd_ready) check("send_timeout", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Wait for a response (at a negedge) and return its contents.
  task automatic wait_rsp(input string name, output res_t r);
    int k;
    r = '0;
    k = 0;
    @(negedge clk);
    while (!bus.rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.rsp_valid) check({name, "_timeout"}, {31'd0, bus.rsp_valid}, 32'd1);
    r = '{y: bus.rsp_y, zero: bus.rsp_zero, cout: bus.rsp_cout, borrow: bus.rsp_borrow};
  endtask

  task automatic check_rsp(input string name, input res_t got, input logic [7:0] y,
                           input logic z, input logic c, input logic b);
    check({name, "_y"}, {24'd0, got.y}, {24'd0, y});
    check({name, "_flags"}, {29'd0, got.zero, got.cout, got.borrow}, {29'd0, z, c, b});
  endtask

  // One command with rsp_ready high; leaves time at posedge+1 after handshake.
  task automatic run_one(input string name, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic acc,
                         input logic [7:0] y, input logic z, input logic c, input logic br);
    res_t r;
    send(op, a, b, acc);
    wait_rsp(name, r);
    check_rsp(name, r, y, z, c, br);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    check({tag, "_alu_regs"}, {12'd0, bus.alu_a, bus.alu_b, bus.alu_sel}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_rsp_data"}, {21'd0, bus.rsp_y, bus.rsp_zero, bus.rsp_cout, bus.rsp_borrow}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    res_t r;
    int   k;
    int   t_prev;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_acc   = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add: accepted at edge t, valid after t+2.
    send(4'b0000, 8'hF0, 8'h20, 1'b0);
    @(negedge clk);
    check("lat_t0_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check("lat_t1_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("lat_t1_alu", {12'd0, bus.alu_a, bus.alu_b, bus.alu_sel}, {12'd0, 8'hF0, 8'h20, 4'h0});
    @(negedge clk);
    check("lat_t2_valid", {31'd0, bus.rsp_valid}, 32'd1);
    r = '{y: bus.rsp_y, zero: bus.rsp_zero, cout: bus.rsp_cout, borrow: bus.rsp_borrow};
    check_rsp("add_f0_20", r, 8'h10, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    run_one("sub_borrow", 4'b0001, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1);
    run_one("sub_zero",   4'b0001, 8'h07, 8'h07, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_one("and",        4'b0010, 8'hCC, 8'hAA, 1'b0, 8'h88, 1'b0, 1'b0, 1'b0);
    run_one("or",         4'b0011, 8'hCC, 8'hAA, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0);
    run_one("xor",        4'b0100, 8'hCC, 8'hAA, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0);
    run_one("illegal",    4'b1010, 8'h33, 8'h44, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_one("acc_seed",   4'b0000, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    run_one("acc_chain",  4'b0000, 8'h10, 8'h04, 1'b1, ACC_EN ? 8'h07 : 8'h14, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Backpressure: 4 buffered plus 1 held in RESP fills the block.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'b0000, 8'(8'h10 + i), 8'h01, 1'b0);
    check("ready_after4", {31'd0, bus.cmd_ready}, 32'd1);
    send(4'b0001, 8'h40, 8'h01, 1'b0);
    check("ready_after5", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'b0100;
    bus.cmd_a     = 8'h5A;
    bus.cmd_b     = 8'h0F;
    bus.cmd_acc   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("full_ready", {31'd0, bus.cmd_ready}, 32'd0);
      check("stall_rsp", {23'd0, bus.rsp_valid, bus.rsp_y}, {23'd0, 1'b1, 8'h11});
    end
    bus.rsp_ready = 1'b1;
    t_prev = 0;
    fork
      begin
        k = 0;
        while (!bus.cmd_ready && k < 100) begin
          @(negedge clk);
          k++;
        end
        if (!bus.cmd_ready) check("sixth_timeout", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 6; j++) begin
          int w;
          w = 0;
          while (!bus.rsp_valid && w < 100) begin
            @(negedge clk);
            w++;
          end
          if (!bus.rsp_valid) check("drain_timeout", {31'd0, bus.rsp_valid}, 32'd1);
          if (j > 0) check("drain_spacing", 32'(cyc - t_prev), 32'd2);
          t_prev = cyc;
          @(posedge clk);
          @(negedge clk);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("drained_busy", {31'd0, bus.busy}, 32'd0);

    // Reset while a response is held with two commands queued.
    bus.rsp_ready = 1'b0;
    send(4'b0000, 8'h5A, 8'h11, 1'b0);
    send(4'b0011, 8'hA5, 8'h22, 1'b0);
    send(4'b0010, 8'h3C, 8'h33, 1'b0);
    k = 0;
    @(negedge clk);
    while (!bus.rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("pre_reset_valid", {31'd0, bus.rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_reset_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test earlier");
    $fatal(1, "watchdog");
  end
endmodule
